// File: rtl/aes_mode_engine.sv
// rtl/aes_mode_engine.sv - ECB/CBC/CTR block-cipher mode engine around an iterative AES-128 core
//
// aes_mode_engine ports:
//   i_Clk, i_Rst          clock; asynchronous active-high reset
//   i_fCfg                one-cycle pulse loading i_Mode (0 ECB, 1 CBC, 2 CTR), i_fDec, i_Key, i_IV
//   i_fValid/o_fReady     input block handshake carrying i_Text and i_fLast
//   o_fValid/i_fReady     output block handshake carrying o_Data and o_fLast
//   o_fBusy               a message is in progress
//   o_fErr                sticky configuration error
//
// aes128_core ports:
//   clk, resetn           clock; synchronous active-low reset
//   start, dec            one-cycle start (restarts the core at any time); 1 = decrypt
//   key, din              cipher key and input block, sampled on start
//   dout, done            result block; one-cycle done pulse, dout holds until the next start

module aes128_core (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         dec,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic         done
);

  typedef enum logic [1:0] {C_IDLE, C_EXP, C_ENC, C_DEC} cstate_t;

  cstate_t      cst;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   rnd;
  logic [7:0]   rc;
  logic [127:0] rk_fwd;
  logic [127:0] rk_inv;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) as a^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gmul(a, a);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h01;
    for (int j = 1; j < 10; j++) begin
      if (4'(j) < r) v = xt(v);
    end
    return v;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] r);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {r, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Recovers the previous round key from the current one.
  function automatic logic [127:0] key_inv(input logic [127:0] n, input logic [7:0] r);
    logic [31:0] w0, w1, w2, w3;
    w3 = n[31:0] ^ n[63:32];
    w2 = n[63:32] ^ n[95:64];
    w1 = n[95:64] ^ n[127:96];
    w0 = n[127:96] ^ sub_rot(w3) ^ {r, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] mcoef(input logic inv, input int k);
    case (k)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  // Byte k of the state is bits [127-8k -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic inv, input logic last);
    logic [7:0]   t [16];
    logic [7:0]   m [4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) t[r + 4*c] = inv_sbox(s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
        else     t[r + 4*c] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      end
    end
    if (inv) begin
      for (int b = 0; b < 16; b++) t[b] = t[b] ^ k[127 - 8*b -: 8];
    end
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < 4; i++) begin
          m[i] = 8'h00;
          for (int j = 0; j < 4; j++) m[i] = m[i] ^ gmul(mcoef(inv, (j - i + 4) % 4), t[4*c + j]);
        end
        for (int i = 0; i < 4; i++) t[4*c + i] = m[i];
      end
    end
    if (!inv) begin
      for (int b = 0; b < 16; b++) t[b] = t[b] ^ k[127 - 8*b -: 8];
    end
    for (int b = 0; b < 16; b++) o[127 - 8*b -: 8] = t[b];
    return o;
  endfunction

  assign rc     = rcon(rnd);
  assign rk_fwd = key_fwd(rk, rc);
  assign rk_inv = key_inv(rk, rc);
  assign dout   = st;

  // Decrypt first walks the schedule forward to round key 10 (C_EXP), then
  // runs the inverse rounds while stepping the schedule backwards.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cst  <= C_IDLE;
      st   <= '0;
      rk   <= '0;
      rnd  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rk  <= key;
        rnd <= 4'd1;
        if (dec) begin
          st  <= din;
          cst <= C_EXP;
        end else begin
          st  <= din ^ key;
          cst <= C_ENC;
        end
      end else begin
        case (cst)
          C_ENC: begin
            st <= aes_round(st, rk_fwd, 1'b0, rnd == 4'd10);
            rk <= rk_fwd;
            if (rnd == 4'd10) begin
              done <= 1'b1;
              cst  <= C_IDLE;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
          C_EXP: begin
            rk <= rk_fwd;
            if (rnd == 4'd10) begin
              st  <= st ^ rk_fwd;
              cst <= C_DEC;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
          C_DEC: begin
            st <= aes_round(st, rk_inv, 1'b1, rnd == 4'd1);
            rk <= rk_inv;
            if (rnd == 4'd1) begin
              done <= 1'b1;
              cst  <= C_IDLE;
            end else begin
              rnd <= rnd - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

module aes_mode_engine #(
  parameter int CTR_W     = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_fCfg,
  input  logic [1:0]   i_Mode,
  input  logic         i_fDec,
  input  logic [127:0] i_Key,
  input  logic [127:0] i_IV,
  input  logic         i_fValid,
  output logic         o_fReady,
  input  logic [127:0] i_Text,
  input  logic         i_fLast,
  output logic         o_fValid,
  input  logic         i_fReady,
  output logic [127:0] o_Data,
  output logic         o_fLast,
  output logic         o_fBusy,
  output logic         o_fErr
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  // Shifting by 128 yields 0, so CTR_W = 128 still gives an all-ones mask.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;

  typedef enum logic [1:0] {IDLE, WAIT_IN, RUN, DRAIN} state_t;

  state_t       state_q, state_d;
  logic [1:0]   mode_q;
  logic         dec_q;
  logic [127:0] key_q;
  logic [127:0] chain_q;
  logic [127:0] text_q;
  logic         last_q;
  logic         err_q;

  logic [128:0] fifo_mem [OUT_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [128:0]  head;

  logic         accept, push, pop;
  logic         core_dec, core_done;
  logic [127:0] core_din, core_dout, result;

  assign occupancy = {1'b0, count} + {{CW{1'b0}}, (state_q == RUN)};
  assign o_fReady  = (state_q == WAIT_IN) && (occupancy < (CW+1)'(OUT_DEPTH));
  assign accept    = i_fValid & o_fReady;
  assign push      = (state_q == RUN) & core_done;
  assign o_fValid  = (count != '0);
  assign pop       = o_fValid & i_fReady;
  assign head      = fifo_mem[rd_ptr];
  assign o_Data    = o_fValid ? head[127:0] : '0;
  assign o_fLast   = o_fValid & head[128];
  assign o_fBusy   = (state_q != IDLE);
  assign o_fErr    = err_q;

  // CTR always runs the core forwards; chain_q doubles as the counter block.
  assign core_dec = (mode_q != 2'd2) & dec_q;

  always_comb begin
    core_din = i_Text;
    if (mode_q == 2'd2)                core_din = chain_q;
    else if (mode_q == 2'd1 && !dec_q) core_din = i_Text ^ chain_q;
  end

  always_comb begin
    result = core_dout;
    if (mode_q == 2'd2)               result = text_q ^ core_dout;
    else if (mode_q == 2'd1 && dec_q) result = core_dout ^ chain_q;
  end

  aes128_core u_core (
    .clk    (i_Clk),
    .resetn (~i_Rst),
    .start  (accept),
    .dec    (core_dec),
    .key    (key_q),
    .din    (core_din),
    .dout   (core_dout),
    .done   (core_done)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_fCfg && i_Mode != 2'd3) state_d = WAIT_IN;
      WAIT_IN: if (accept) state_d = RUN;
      RUN:     if (core_done) state_d = last_q ? DRAIN : WAIT_IN;
      DRAIN:   if (count == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode_q  <= '0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      chain_q <= '0;
      text_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (i_fCfg) begin
        if (state_q == IDLE && i_Mode != 2'd3) begin
          mode_q  <= i_Mode;
          dec_q   <= i_fDec;
          key_q   <= i_Key;
          chain_q <= i_IV;
          err_q   <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (accept) begin
        text_q <= i_Text;
        last_q <= i_fLast;
      end
      if (push) begin
        if (mode_q == 2'd1)      chain_q <= dec_q ? text_q : core_dout;
        else if (mode_q == 2'd2) chain_q <= (chain_q & ~CTR_MASK) | ((chain_q + 128'd1) & CTR_MASK);
        wr_ptr <= (wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) fifo_mem[wr_ptr] <= {last_q, result};
  end

endmodule

// File: tb/tb_aes_mode_engine.sv
// tb/tb_aes_mode_engine.sv - directed-vector bench for aes_mode_engine
module tb_aes_mode_engine;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CTR0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] CTRW = 128'h000000000000000000000000ffffffff;
  localparam logic [127:0] E0_0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] SP_P [4] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                                        128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                        128'h30c81c46a35ce411e5fbc1191a0a52ef,
                                        128'hf69f2445df4f9b17ad2b417be66c3710};
  localparam logic [127:0] CBC_C [4] = '{128'h7649abac8119b246cee98e9b12e9197d,
                                         128'h5086cb9b507219ee95db113a917678b2,
                                         128'h73bed6b8e3c1743b7116e69e22229516,
                                         128'h3ff1caa1681fac09120eca307586e1a7};
  localparam logic [127:0] CTR_C [2] = '{128'h874d6191b620e3261bef6864990db6ce,
                                         128'h9806f66b7970fdff8617187bb9fffdff};

  logic         i_Clk, i_Rst, i_fCfg, i_fDec, i_fValid, i_fLast, i_fReady;
  logic [1:0]   i_Mode;
  logic [127:0] i_Key, i_IV, i_Text;
  logic         o_fReady, o_fValid, o_fLast, o_fBusy, o_fErr;
  logic [127:0] o_Data;

  int vectors = 0;
  int miscompares = 0;

  aes_mode_engine #(.CTR_W(32), .OUT_DEPTH(2)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_fCfg(i_fCfg), .i_Mode(i_Mode), .i_fDec(i_fDec),
    .i_Key(i_Key), .i_IV(i_IV), .i_fValid(i_fValid), .o_fReady(o_fReady), .i_Text(i_Text),
    .i_fLast(i_fLast), .o_fValid(o_fValid), .i_fReady(i_fReady), .o_Data(o_Data),
    .o_fLast(o_fLast), .o_fBusy(o_fBusy), .o_fErr(o_fErr)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_cfg(input logic [1:0] mode, input logic dec, input logic [127:0] key,
                        input logic [127:0] iv);
    i_Mode = mode; i_fDec = dec; i_Key = key; i_IV = iv; i_fCfg = 1'b1;
    @(negedge i_Clk);
    i_fCfg = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] t, input logic last);
    int n = 0;
    i_Text = t; i_fLast = last; i_fValid = 1'b1;
    while (!o_fReady && n < 500) begin @(negedge i_Clk); n++; end
    if (!o_fReady) begin
      miscompares++;
      $display("FAIL send timeout: o_fReady=%b required 1", o_fReady);
    end
    @(negedge i_Clk);
    i_fValid = 1'b0;
  endtask

  task automatic recv_blk(output logic [127:0] d, output logic l);
    int n = 0;
    i_fReady = 1'b1;
    while (!o_fValid && n < 500) begin @(negedge i_Clk); n++; end
    if (!o_fValid) begin
      miscompares++;
      $display("FAIL recv timeout: o_fValid=%b required 1", o_fValid);
    end
    d = o_Data; l = o_fLast;
    @(negedge i_Clk);
    i_fReady = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_fBusy && n < 200) begin @(negedge i_Clk); n++; end
    if (o_fBusy) begin
      miscompares++;
      $display("FAIL idle timeout: o_fBusy=%b required 0", o_fBusy);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({o_fValid, o_fReady, o_fBusy, o_fErr, o_fLast} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset flags: got %b required 00000", {o_fValid, o_fReady, o_fBusy, o_fErr, o_fLast});
    end
    vectors++;
    if (o_Data !== 128'h0) begin
      miscompares++;
      $display("FAIL reset data: got %h required 0", o_Data);
    end
  endtask

  task automatic test_ecb_enc();
    logic [127:0] d; logic l;
    do_cfg(2'd0, 1'b0, K1, 128'h0);
    vectors++;
    if (o_fReady !== 1'b1 || o_fBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL ecb_enc cfg: ready=%b busy=%b required 1 1", o_fReady, o_fBusy);
    end
    send_blk(PT1, 1'b1);
    recv_blk(d, l);
    vectors++;
    if (d !== CT1) begin miscompares++; $display("FAIL ecb_enc data: got %h required %h", d, CT1); end
    vectors++;
    if (l !== 1'b1) begin miscompares++; $display("FAIL ecb_enc last: got %b required 1", l); end
    repeat (2) @(negedge i_Clk);
    vectors++;
    if (o_fBusy !== 1'b0) begin miscompares++; $display("FAIL ecb_enc busy: got %b required 0", o_fBusy); end
  endtask

  task automatic test_ecb_dec();
    logic [127:0] d; logic l;
    do_cfg(2'd0, 1'b1, K1, 128'h0);
    send_blk(CT1, 1'b1);
    recv_blk(d, l);
    vectors++;
    if (d !== PT1 || l !== 1'b1) begin
      miscompares++;
      $display("FAIL ecb_dec: got %h/%b required %h/1", d, l, PT1);
    end
    wait_idle();
  endtask

  task automatic test_cbc(input logic dec);
    logic [127:0] d; logic l;
    logic [127:0] src, exp;
    do_cfg(2'd1, dec, K2, IV2);
    for (int i = 0; i < 2; i++) begin
      src = dec ? CBC_C[i] : SP_P[i];
      exp = dec ? SP_P[i] : CBC_C[i];
      send_blk(src, i == 1);
      recv_blk(d, l);
      vectors++;
      if (d !== exp || l !== (i == 1)) begin
        miscompares++;
        $display("FAIL cbc dec=%0b blk%0d: got %h/%b required %h/%b", dec, i, d, l, exp, i == 1);
      end
    end
    wait_idle();
  endtask

  task automatic test_ctr();
    logic [127:0] d; logic l;
    do_cfg(2'd2, 1'b1, K2, CTR0);
    for (int i = 0; i < 2; i++) begin
      send_blk(SP_P[i], i == 1);
      recv_blk(d, l);
      vectors++;
      if (d !== CTR_C[i]) begin
        miscompares++;
        $display("FAIL ctr blk%0d: got %h required %h", i, d, CTR_C[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_ctr_wrap();
    logic [127:0] d; logic l;
    do_cfg(2'd2, 1'b0, 128'h0, CTRW);
    send_blk(128'h0, 1'b0);
    recv_blk(d, l);
    vectors++;
    if (l !== 1'b0) begin miscompares++; $display("FAIL ctr_wrap last0: got %b required 0", l); end
    send_blk(128'h0, 1'b1);
    recv_blk(d, l);
    vectors++;
    if (d !== E0_0 || l !== 1'b1) begin
      miscompares++;
      $display("FAIL ctr_wrap blk1: got %h/%b required %h/1", d, l, E0_0);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [127:0] got [4];
    logic         gl [4];
    do_cfg(2'd1, 1'b0, K2, IV2);
    i_fReady = 1'b0;
    send_blk(SP_P[0], 1'b0);
    send_blk(SP_P[1], 1'b0);
    i_Text = SP_P[2]; i_fLast = 1'b0; i_fValid = 1'b1;
    repeat (30) @(negedge i_Clk);
    vectors++;
    if (o_fReady !== 1'b0 || o_fValid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp full: ready=%b valid=%b required 0 1", o_fReady, o_fValid);
    end
    vectors++;
    if (o_Data !== CBC_C[0]) begin miscompares++; $display("FAIL bp head: got %h required %h", o_Data, CBC_C[0]); end
    repeat (5) @(negedge i_Clk);
    vectors++;
    if (o_Data !== CBC_C[0] || o_fReady !== 1'b0) begin
      miscompares++;
      $display("FAIL bp hold: got %h ready=%b required %h 0", o_Data, o_fReady, CBC_C[0]);
    end
    fork
      begin
        send_blk(SP_P[2], 1'b0);
        send_blk(SP_P[3], 1'b1);
      end
      begin
        for (int k = 0; k < 4; k++) recv_blk(got[k], gl[k]);
      end
    join
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got[k] !== CBC_C[k] || gl[k] !== (k == 3)) begin
        miscompares++;
        $display("FAIL bp out%0d: got %h/%b required %h/%b", k, got[k], gl[k], CBC_C[k], k == 3);
      end
    end
    wait_idle();
  endtask

  task automatic test_err_mode3();
    logic [127:0] d; logic l;
    do_cfg(2'd3, 1'b0, K1, 128'h0);
    vectors++;
    if (o_fErr !== 1'b1 || o_fBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL mode3: err=%b busy=%b required 1 0", o_fErr, o_fBusy);
    end
    do_cfg(2'd0, 1'b0, K1, 128'h0);
    vectors++;
    if (o_fErr !== 1'b0 || o_fBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL mode3 recfg: err=%b busy=%b required 0 1", o_fErr, o_fBusy);
    end
    send_blk(PT1, 1'b1);
    recv_blk(d, l);
    vectors++;
    if (d !== CT1) begin miscompares++; $display("FAIL mode3 data: got %h required %h", d, CT1); end
    wait_idle();
  endtask

  task automatic test_cfg_during_run();
    logic [127:0] d; logic l;
    do_cfg(2'd0, 1'b0, K1, 128'h0);
    send_blk(PT1, 1'b1);
    do_cfg(2'd2, 1'b1, K2, CTR0);
    vectors++;
    if (o_fErr !== 1'b1 || o_fBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_run: err=%b busy=%b required 1 1", o_fErr, o_fBusy);
    end
    recv_blk(d, l);
    vectors++;
    if (d !== CT1 || l !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_run data: got %h/%b required %h/1", d, l, CT1);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] d; logic l;
    do_cfg(2'd0, 1'b0, K1, 128'h0);
    i_fReady = 1'b0;
    send_blk(PT1, 1'b0);
    send_blk(PT1, 1'b0);
    do_cfg(2'd3, 1'b0, K1, 128'h0);
    vectors++;
    if ({o_fValid, o_fBusy, o_fErr} !== 3'b111) begin
      miscompares++;
      $display("FAIL rst pre: valid/busy/err=%b required 111", {o_fValid, o_fBusy, o_fErr});
    end
    i_Rst = 1'b1;
    #1;
    vectors++;
    if ({o_fValid, o_fBusy, o_fErr, o_fReady} !== 4'b0000 || o_Data !== 128'h0) begin
      miscompares++;
      $display("FAIL rst async: flags=%b data=%h required 0000 0", {o_fValid, o_fBusy, o_fErr, o_fReady}, o_Data);
    end
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    repeat (20) @(negedge i_Clk);
    vectors++;
    if (o_fValid !== 1'b0 || o_fBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst after: valid=%b busy=%b required 0 0", o_fValid, o_fBusy);
    end
    do_cfg(2'd0, 1'b1, K1, 128'h0);
    send_blk(CT1, 1'b1);
    recv_blk(d, l);
    vectors++;
    if (d !== PT1 || l !== 1'b1) begin
      miscompares++;
      $display("FAIL rst recover: got %h/%b required %h/1", d, l, PT1);
    end
    wait_idle();
  endtask

  initial begin
    i_Rst = 1'b1; i_fCfg = 1'b0; i_Mode = 2'd0; i_fDec = 1'b0; i_Key = '0; i_IV = '0;
    i_fValid = 1'b0; i_Text = '0; i_fLast = 1'b0; i_fReady = 1'b0;
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    @(negedge i_Clk);
    test_reset();
    test_ecb_enc();
    test_ecb_dec();
    test_cbc(1'b0);
    test_cbc(1'b1);
    test_ctr();
    test_ctr_wrap();
    test_backpressure();
    test_err_mode3();
    test_cfg_during_run();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_mode_engine.md
Name: aes_mode_engine

Overview:
- Parametrised block-cipher mode engine around one instance of the team's iterative AES-128 core.
- Adds ECB, CBC and CTR chaining, valid/ready streaming on both sides, a configurable output buffer and multi-block messages delimited by a last flag.
- Sits between the bus-side DMA stream and the AES core. It replaces direct start/done control of the core.

Parameters:
- CTR_W, 32, number of low-order counter bits incremented in CTR mode (1..128); upper bits never change.
- OUT_DEPTH, 2, output FIFO depth in 128-bit entries (power of two, >=1).

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  reset. Asynchronous, active-high.
- i_fCfg  in  1  single-cycle pulse; loads the mode, direction, key and IV/counter.
- i_Mode  in  2  0=ECB, 1=CBC, 2=CTR, 3=reserved.
- i_fDec  in  1  1=decrypt. Ignored in CTR mode.
- i_Key  in  128  cipher key.
- i_IV  in  128  CBC IV or CTR initial counter block.
- i_fValid  in  1  input block valid.
- o_fReady  out  1  engine accepts an input block.
- i_Text  in  128  input block.
- i_fLast  in  1  marks the final block of the message.
- o_fValid  out  1  output block valid.
- i_fReady  in  1  downstream accepts the output block.
- o_Data  out  128  output block.
- o_fLast  out  1  output block is the last block of the message.
- o_fBusy  out  1  message in progress (state is not IDLE).
- o_fErr  out  1  sticky configuration error.

Behaviour:
- Reset (asynchronous, any state, including mid-block):
  - State goes to IDLE.
  - FIFO is emptied.
  - The key, chain and counter registers are cleared to 0.
  - All outputs are 0.
  - The core's active-low reset is driven from the inverse of i_Rst.
- States: IDLE, WAIT_IN, RUN, DRAIN.
- IDLE:
  - An i_fCfg pulse with i_Mode != 3 latches the mode, direction, key and IV into the chain/counter register, clears o_fErr, and moves to WAIT_IN.
  - An i_fCfg pulse with i_Mode == 3 sets o_fErr and the engine stays in IDLE.
- An i_fCfg pulse in any state other than IDLE is ignored and sets o_fErr.
- WAIT_IN:
  - o_fReady = 1 exactly when the FIFO count plus in-flight blocks is less than OUT_DEPTH.
  - On i_fValid & o_fReady, the engine latches i_Text and i_fLast, issues a one-cycle start to the core in the same cycle, and moves to RUN.
- Core input and direction by mode:
  - ECB: i_Text, direction i_fDec.
  - CBC encrypt: i_Text XOR chain.
  - CBC decrypt: i_Text, direction decrypt.
  - CTR: the counter block, always encrypt.
- RUN:
  - Waits for the core done pulse, then pushes the result into the FIFO in that cycle.
  - Result by mode:
    - ECB: core output.
    - CBC encrypt: core output; chain becomes the core output.
    - CBC decrypt: core output XOR chain; chain becomes the latched input block.
    - CTR: latched input XOR core output. The low CTR_W bits of the counter increment modulo 2^CTR_W; bits above CTR_W are unchanged (a wrap does not carry).
  - Next state: DRAIN if the block was marked last, otherwise WAIT_IN.
- DRAIN: returns to IDLE when the FIFO is empty. A new configuration is required for the next message.
- Output FIFO:
  - o_fValid = not empty; o_Data and o_fLast show the head entry.
  - Pop on o_fValid & i_fReady.
  - A simultaneous push and pop in the same cycle leaves the count unchanged.
  - The FIFO never overflows, because o_fReady accounts for in-flight blocks.
  - o_Data is held stable while o_fValid=1 and i_fReady=0.
- Latency: the first o_fValid is asserted one cycle after the core done pulse for that block.
- Ordering: one block is in flight at a time. Output order equals input order.
- A core done pulse outside RUN is ignored.

Test Plan:
- ECB encrypt:
  - Stimulus: cfg mode 0, fDec 0, key 000102030405060708090a0b0c0d0e0f; input 00112233445566778899aabbccddeeff with last=1.
  - Required: o_Data 69c4e0d86a7b0430d8cdb78070b4c55a, o_fLast=1, then o_fBusy drops.
- ECB decrypt: same key, fDec 1, input 69c4e0d86a7b0430d8cdb78070b4c55a -> output 00112233445566778899aabbccddeeff.
- CBC (SP800-38A):
  - Setup: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f.
  - Encrypt: P1 6bc1bee22e409f96e93d7e117393172a, P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2.
  - Decrypt: the ciphertexts fed back with fDec 1 return P1 and P2.
- CTR:
  - Encrypt: same key, counter f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, P1 6bc1bee22e409f96e93d7e117393172a -> 874d6191b620e3261bef6864990db6ce; the second counter block is f0f1f2f3f4f5f6f7f8f9fafbfcfdff00.
  - Wrap: counter with low 32 bits ffffffff -> next counter has low 32 bits 00000000 and upper 96 bits unchanged.
- Backpressure:
  - Stimulus: OUT_DEPTH=2, i_fReady=0, four blocks offered.
  - Required: after two results are buffered, o_fReady=0 and o_Data is stable. After i_fReady=1, all four blocks emerge in order with no loss.
- Errors and reset:
  - cfg with mode 3 -> o_fErr=1 and the engine stays IDLE.
  - cfg during RUN -> o_fErr=1 and the message continues unaffected.
  - i_Rst pulse during RUN -> o_fValid=0, o_fBusy=0, o_fErr=0; the next cfg plus one block produces the correct result.
